// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, registered borrow, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             bit_out,
  output logic             bit_valid,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: an operation is accepted on a rising edge where start=1 and ready=1;
  // start at any other time is dropped. done is a one-cycle valid pulse for diff/borrow_out.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               d, bnext, last;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  assign d     = sa[0] ^ sb[0] ^ br;
  assign bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == S_IDLE);
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    bit_valid = busy;
    bit_out   = busy ? d : 1'b0;
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        sa   <= a;
        sb   <= b;
        br   <= bin;
        cnt  <= '0;
        diff <= '0;
      end else if (state == S_RUN) begin
        diff <= {d, diff[WIDTH-1:1]};
        sa   <= {1'b0, sa[WIDTH-1:1]};
        sb   <= {1'b0, sb[WIDTH-1:1]};
        br   <= bnext;
        cnt  <= last ? cnt : cnt + CNT_W'(1);
        if (last) begin
          borrow_out <= bnext;
`ifdef SERIAL_SUB_OVF_EN
          // On the final bit sa[0]/sb[0] hold the original operand MSBs and d is the result MSB.
          ovf <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners plus randomized operations
// against an arithmetic reference model. Honors SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         ready, busy, done, borrow_out, bit_out, bit_valid;
  logic [W-1:0] diff;
  logic [1:0]   state_dbg;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: plain unsigned/signed arithmetic.
  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c);
    logic [W:0] full;
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    return full[W-1:0];
  endfunction

  function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
    return ({1'b0, x} < ({1'b0, y} + {{W{1'b0}}, c}));
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx, sy, sd;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sd = sx - sy - int'(c);
    return (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1) - 1));
  endfunction

  // Driver helpers
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready timeout got ready=%b exp 1", ready);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input string tag);
    logic [W-1:0] ed, bits;
    logic         eb;
    wait_ready();
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    ed = model_diff(ta, tb, tbin);
    eb = model_borrow(ta, tb, tbin);
    for (int i = 0; i < W; i++) exp_q.push_back(W'((ed >> i) & 1));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bits = exp_q.pop_front();
      checks++;
      if (busy !== 1'b1 || bit_valid !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags bit%0d got busy=%b bv=%b rdy=%b done=%b exp 1 1 0 0",
                 tag, i, busy, bit_valid, ready, done);
      end
      checks++;
      if (bit_out !== bits[0]) begin
        errors++;
        $display("FAIL %s bit_out[%0d] got %b exp %b", tag, i, bit_out, bits[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got done=%b busy=%b rdy=%b exp 1 0 0", tag, done, busy, ready);
    end
    checks++;
    if (diff !== ed || borrow_out !== eb) begin
      errors++;
      $display("FAIL %s result got diff=%0h bo=%b exp diff=%0h bo=%b", tag, diff, borrow_out, ed, eb);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== model_ovf(ta, tb, tbin)) begin
      errors++;
      $display("FAIL %s ovf got %b exp %b", tag, ovf, model_ovf(ta, tb, tbin));
    end
`endif
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== ed || borrow_out !== eb) begin
      errors++;
      $display("FAIL %s idle_hold got rdy=%b done=%b diff=%0h bo=%b exp 1 0 %0h %b",
               tag, ready, done, diff, borrow_out, ed, eb);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bit_valid !== 1'b0 ||
        bit_out !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b busy=%b done=%b bv=%b bit=%b diff=%0h bo=%b",
               ready, busy, done, bit_valid, bit_out, diff, borrow_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8'h35, 8'h12, 1'b0, "d_35_12");
    run_op(8'h00, 8'h01, 1'b0, "d_00_01");
    run_op(8'h80, 8'h01, 1'b0, "d_80_01");
    run_op(8'h10, 8'h0F, 1'b1, "d_10_0f_b");
    run_op(8'h00, 8'hFF, 1'b1, "d_00_ff_b");
    run_op(8'hFF, 8'hFF, 1'b1, "d_ff_ff_b");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), "rand");
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [W-1:0] seen;
    dones = 0;
    seen = '0;
    wait_ready();
    start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        seen = diff;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d exp 1", dones);
    end
    checks++;
    if (seen !== 8'h02 || diff !== 8'h02) begin
      errors++;
      $display("FAIL ignore_result got %0h/%0h exp 02", seen, diff);
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got rdy=%b busy=%b exp 1 0", ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    wait_ready();
    start = 1'b1; a = 8'h35; b = 8'h12; bin = 1'b0;
    @(posedge clk);
    repeat (W) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || diff !== 8'h23) begin
      errors++;
      $display("FAIL b2b_first got done=%b diff=%0h exp 1 23", done, diff);
    end
    a = 8'h10; b = 8'h0F; bin = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_gap got %b exp 1", ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b exp 1", busy);
    end
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 1 && dones == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got dones=%0d diff=%0h bo=%b exp 1 00 0", dones, diff, borrow_out);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    wait_ready();
    start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (diff !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        bit_valid !== 1'b0 || bit_out !== 1'b0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got diff=%0h rdy=%b busy=%b done=%b bv=%b bit=%b bo=%b",
               diff, ready, busy, done, bit_valid, bit_out, borrow_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_no_done got dones=%0d rdy=%b exp 0 1", dones, ready);
    end
    run_op(8'h09, 8'h04, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
